// File: rtl/sfr_gpio.sv
// sfr_gpio: N_PORTS x 8-bit GPIO on the r8051 SFR bus.
// OUT/DIR latches, synchronised inputs, edge-triggered flags and irq.
module sfr_gpio #(
   parameter int         N_PORTS     = 2,
   parameter logic [7:0] BASE_ADDR   = 8'hC0,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] RESET_OUT   = 8'hFF,
   parameter logic [7:0] RESET_DIR   = 8'hFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sfr_rd_en,
   input  logic [7:0]             sfr_rd_addr,
   output logic [7:0]             sfr_rd_byte,
   output logic                   sfr_rd_hit,
   input  logic                   sfr_wr_en,
   input  logic [7:0]             sfr_wr_addr,
   input  logic [7:0]             sfr_wr_byte,
   input  logic [8*N_PORTS-1:0]   pin_in,
   output logic [8*N_PORTS-1:0]   pin_out,
   output logic [8*N_PORTS-1:0]   pin_oe,
   output logic                   irq
);

   localparam logic [8:0] WIN = 9'(N_PORTS * 8);
   localparam int CW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES + 1);

   localparam logic [2:0] R_OUT   = 3'd0;
   localparam logic [2:0] R_DIR   = 3'd1;
   localparam logic [2:0] R_IN    = 3'd2;
   localparam logic [2:0] R_IEN   = 3'd3;
   localparam logic [2:0] R_IEDGE = 3'd4;
   localparam logic [2:0] R_IFLG  = 3'd5;

   logic [N_PORTS-1:0][7:0] out_q;
   logic [N_PORTS-1:0][7:0] dir_q;
   logic [N_PORTS-1:0][7:0] ien_q;
   logic [N_PORTS-1:0][7:0] iedge_q;
   logic [N_PORTS-1:0][7:0] iflg_q;
   logic [N_PORTS-1:0][7:0] prev_q;
   logic [N_PORTS-1:0][7:0] in_v;
   logic [N_PORTS-1:0][7:0] set_v;
   logic [N_PORTS-1:0][7:0] clr_v;

   logic [SYNC_STAGES-1:0][8*N_PORTS-1:0] sync_q;
   logic [CW-1:0] cnt_q;
   logic          settled;

   logic [7:0]         rd_off;
   logic [7:0]         wr_off;
   logic               rd_in_win;
   logic               wr_in_win;
   logic [7:0]         rd_val;
   logic [N_PORTS-1:0] wr_port;

   // Window decode: offset wraps for addresses below BASE_ADDR,
   // so a single unsigned compare rejects both sides.
   assign rd_off    = sfr_rd_addr - BASE_ADDR;
   assign wr_off    = sfr_wr_addr - BASE_ADDR;
   assign rd_in_win = ({1'b0, rd_off} < WIN);
   assign wr_in_win = ({1'b0, wr_off} < WIN);

   assign in_v    = sync_q[SYNC_STAGES-1];
   assign settled = (cnt_q == CNT_MAX);
   assign pin_out = out_q;
   assign pin_oe  = dir_q;

   // Read mux over the current (pre-write) register contents.
   always_comb begin
      rd_val = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (rd_off[5:3] == 3'(p)) begin
            case (rd_off[2:0])
               R_OUT:   rd_val = out_q[p];
               R_DIR:   rd_val = dir_q[p];
               R_IN:    rd_val = in_v[p];
               R_IEN:   rd_val = ien_q[p];
               R_IEDGE: rd_val = iedge_q[p];
               R_IFLG:  rd_val = iflg_q[p];
               default: rd_val = '0;
            endcase
         end
      end
   end

   // Per-port write select and write-1-to-clear mask for IFLG.
   always_comb begin
      wr_port = '0;
      clr_v   = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         wr_port[p] = sfr_wr_en & wr_in_win & (wr_off[5:3] == 3'(p));
         if (wr_port[p] && (wr_off[2:0] == R_IFLG))
            clr_v[p] = sfr_wr_byte;
      end
   end

   // Edge detect against IEDGE, gated until the sync chain has settled.
   always_comb begin
      set_v = '0;
      if (settled)
         set_v = (~prev_q & in_v & iedge_q)
               | (prev_q & ~in_v & ~iedge_q);
   end

   // Configuration registers written from the SFR bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= {N_PORTS{RESET_OUT}};
         dir_q   <= {N_PORTS{RESET_DIR}};
         ien_q   <= '0;
         iedge_q <= '0;
      end else begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (wr_port[p]) begin
               case (wr_off[2:0])
                  R_OUT:   out_q[p]   <= sfr_wr_byte;
                  R_DIR:   dir_q[p]   <= sfr_wr_byte;
                  R_IEN:   ien_q[p]   <= sfr_wr_byte;
                  R_IEDGE: iedge_q[p] <= sfr_wr_byte;
                  default: ;
               endcase
            end
         end
      end
   end

   // Interrupt flags: a new edge overrides a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst)
         iflg_q <= '0;
      else
         iflg_q <= (iflg_q & ~clr_v) | set_v;
   end

   // Pin synchroniser, previous-IN flop and post-reset settle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
         prev_q <= in_v;
         if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // Registered read port; holds while no strobe is present.
   always_ff @(posedge clk) begin
      if (rst) begin
         sfr_rd_byte <= '0;
         sfr_rd_hit  <= 1'b0;
      end else if (sfr_rd_en) begin
         sfr_rd_hit  <= rd_in_win;
         sfr_rd_byte <= rd_in_win ? rd_val : 8'h00;
      end
   end

   // Interrupt request from enabled, pending flags on any port.
   always_ff @(posedge clk) begin
      if (rst)
         irq <= 1'b0;
      else
         irq <= |(iflg_q & ien_q);
   end

endmodule

// File: tb/tb_sfr_gpio.sv
// tb_sfr_gpio: directed bench for sfr_gpio (N_PORTS = 2, base C0).
// Each task drives one scenario and checks hand-computed values.
module tb_sfr_gpio;

   logic        clk = 1'b0;
   logic        rst;
   logic        sfr_rd_en;
   logic [7:0]  sfr_rd_addr;
   logic [7:0]  sfr_rd_byte;
   logic        sfr_rd_hit;
   logic        sfr_wr_en;
   logic [7:0]  sfr_wr_addr;
   logic [7:0]  sfr_wr_byte;
   logic [15:0] pin_in;
   logic [15:0] pin_out;
   logic [15:0] pin_oe;
   logic        irq;

   int checks = 0;
   int errors = 0;

   sfr_gpio dut (
      .clk         (clk),
      .rst         (rst),
      .sfr_rd_en   (sfr_rd_en),
      .sfr_rd_addr (sfr_rd_addr),
      .sfr_rd_byte (sfr_rd_byte),
      .sfr_rd_hit  (sfr_rd_hit),
      .sfr_wr_en   (sfr_wr_en),
      .sfr_wr_addr (sfr_wr_addr),
      .sfr_wr_byte (sfr_wr_byte),
      .pin_in      (pin_in),
      .pin_out     (pin_out),
      .pin_oe      (pin_oe),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
      sfr_wr_en   = 1'b1;
      sfr_wr_addr = a;
      sfr_wr_byte = d;
      @(posedge clk);
      #1;
      sfr_wr_en = 1'b0;
   endtask

   task automatic do_rd(input logic [7:0] a,
                        output logic [7:0] b, output logic h);
      sfr_rd_en   = 1'b1;
      sfr_rd_addr = a;
      @(posedge clk);
      #1;
      sfr_rd_en = 1'b0;
      b = sfr_rd_byte;
      h = sfr_rd_hit;
   endtask

   task automatic test_reset;
      logic [7:0] b;
      logic h;
      rst = 1'b1;
      pin_in = 16'hA55A;
      idle(3);
      checks++;
      if (sfr_rd_hit !== 1'b0 || sfr_rd_byte !== 8'h00) begin
         errors++;
         $display("FAIL reset_rd got %b/%h exp 0/00", sfr_rd_hit, sfr_rd_byte);
      end
      checks++;
      if (pin_out !== 16'hFFFF || pin_oe !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_pins got %h/%h exp FFFF/FFFF", pin_out, pin_oe);
      end
      rst = 1'b0;
      idle(10);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got %b exp 0", irq);
      end
      do_rd(8'hC5, b, h);
      checks++;
      if (b !== 8'h00 || h !== 1'b1) begin
         errors++;
         $display("FAIL reset_iflg0 got %h/%b exp 00/1", b, h);
      end
      do_rd(8'hCD, b, h);
      checks++;
      if (b !== 8'h00) begin
         errors++;
         $display("FAIL reset_iflg1 got %h exp 00", b);
      end
      do_rd(8'hC2, b, h);
      checks++;
      if (b !== 8'h5A) begin
         errors++;
         $display("FAIL reset_in0 got %h exp 5A", b);
      end
      do_rd(8'hCA, b, h);
      checks++;
      if (b !== 8'hA5) begin
         errors++;
         $display("FAIL reset_in1 got %h exp A5", b);
      end
   endtask

   task automatic test_rw;
      logic [7:0] b;
      logic h;
      do_rd(8'hD0, b, h);
      do_wr(8'hC0, 8'h3C);
      checks++;
      if (pin_out !== 16'hFF3C) begin
         errors++;
         $display("FAIL wr_out got %h exp FF3C", pin_out);
      end
      sfr_rd_en   = 1'b1;
      sfr_rd_addr = 8'hC0;
      #2;
      checks++;
      if (sfr_rd_hit !== 1'b0) begin
         errors++;
         $display("FAIL rd_early got %b exp 0", sfr_rd_hit);
      end
      @(posedge clk);
      #1;
      sfr_rd_en = 1'b0;
      checks++;
      if (sfr_rd_byte !== 8'h3C || sfr_rd_hit !== 1'b1) begin
         errors++;
         $display("FAIL rd_out got %h/%b exp 3C/1", sfr_rd_byte, sfr_rd_hit);
      end
      do_wr(8'hC1, 8'h0F);
      checks++;
      if (pin_oe !== 16'hFF0F) begin
         errors++;
         $display("FAIL wr_dir got %h exp FF0F", pin_oe);
      end
      sfr_rd_en   = 1'b1;
      sfr_rd_addr = 8'hC0;
      sfr_wr_en   = 1'b1;
      sfr_wr_addr = 8'hC0;
      sfr_wr_byte = 8'h55;
      @(posedge clk);
      #1;
      sfr_rd_en = 1'b0;
      sfr_wr_en = 1'b0;
      checks++;
      if (sfr_rd_byte !== 8'h3C || pin_out[7:0] !== 8'h55) begin
         errors++;
         $display("FAIL rd_wr_same got %h/%h exp 3C/55", sfr_rd_byte, pin_out[7:0]);
      end
      idle(2);
      checks++;
      if (sfr_rd_byte !== 8'h3C || sfr_rd_hit !== 1'b1) begin
         errors++;
         $display("FAIL rd_hold got %h/%b exp 3C/1", sfr_rd_byte, sfr_rd_hit);
      end
   endtask

   task automatic test_edge_irq;
      logic [7:0] b;
      logic h;
      do_wr(8'hCC, 8'h01);
      do_wr(8'hCB, 8'h01);
      pin_in[8] = 1'b0;
      idle(5);
      do_rd(8'hCD, b, h);
      checks++;
      if (b !== 8'h00) begin
         errors++;
         $display("FAIL fall_ignored got %h exp 00", b);
      end
      pin_in[8] = 1'b1;
      idle(1);
      sfr_rd_en   = 1'b1;
      sfr_rd_addr = 8'hCA;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_c1 got %b exp 0", irq);
      end
      idle(1);
      checks++;
      if (sfr_rd_byte !== 8'hA4) begin
         errors++;
         $display("FAIL in_c2 got %h exp A4", sfr_rd_byte);
      end
      idle(1);
      checks++;
      if (sfr_rd_byte !== 8'hA5 || irq !== 1'b0) begin
         errors++;
         $display("FAIL in_c3 got %h/%b exp A5/0", sfr_rd_byte, irq);
      end
      sfr_rd_addr = 8'hCD;
      idle(1);
      sfr_rd_en = 1'b0;
      checks++;
      if (sfr_rd_byte !== 8'h01 || irq !== 1'b1) begin
         errors++;
         $display("FAIL iflg_c4 got %h/%b exp 01/1", sfr_rd_byte, irq);
      end
   endtask

   task automatic test_w1c;
      logic [7:0] b;
      logic h;
      pin_in[8] = 1'b0;
      idle(5);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_held got %b exp 1", irq);
      end
      pin_in[8] = 1'b1;
      idle(2);
      do_wr(8'hCD, 8'h01);
      do_rd(8'hCD, b, h);
      checks++;
      if (b !== 8'h01) begin
         errors++;
         $display("FAIL set_wins got %h exp 01", b);
      end
      do_wr(8'hCD, 8'hFE);
      do_rd(8'hCD, b, h);
      checks++;
      if (b !== 8'h01) begin
         errors++;
         $display("FAIL w1c_zero got %h exp 01", b);
      end
      do_wr(8'hCD, 8'h01);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_lag got %b exp 1", irq);
      end
      idle(1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_drop got %b exp 0", irq);
      end
      do_rd(8'hCD, b, h);
      checks++;
      if (b !== 8'h00) begin
         errors++;
         $display("FAIL w1c_clr got %h exp 00", b);
      end
   endtask

   task automatic test_decode;
      logic [7:0] b;
      logic h;
      do_rd(8'hC0, b, h);
      do_rd(8'hD0, b, h);
      checks++;
      if (b !== 8'h00 || h !== 1'b0) begin
         errors++;
         $display("FAIL out_win got %h/%b exp 00/0", b, h);
      end
      do_rd(8'hC0, b, h);
      do_rd(8'hBF, b, h);
      checks++;
      if (b !== 8'h00 || h !== 1'b0) begin
         errors++;
         $display("FAIL below_win got %h/%b exp 00/0", b, h);
      end
      do_rd(8'hC6, b, h);
      checks++;
      if (b !== 8'h00 || h !== 1'b1) begin
         errors++;
         $display("FAIL reserved got %h/%b exp 00/1", b, h);
      end
      do_wr(8'hC2, 8'h00);
      do_rd(8'hC2, b, h);
      checks++;
      if (b !== 8'h5A) begin
         errors++;
         $display("FAIL in_ro got %h exp 5A", b);
      end
      do_wr(8'hC7, 8'hFF);
      do_rd(8'hC7, b, h);
      checks++;
      if (b !== 8'h00 || pin_out !== 16'hFF55 || pin_oe !== 16'hFF0F) begin
         errors++;
         $display("FAIL rsv_wr got %h %h %h exp 00 FF55 FF0F", b, pin_out, pin_oe);
      end
   endtask

   task automatic test_reset_midread;
      logic [7:0] b;
      logic h;
      do_wr(8'hCD, 8'hFF);
      pin_in[8] = 1'b0;
      idle(5);
      pin_in[8] = 1'b1;
      idle(5);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst_irq got %b exp 1", irq);
      end
      sfr_rd_en   = 1'b1;
      sfr_rd_addr = 8'hC0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sfr_rd_en = 1'b0;
      checks++;
      if (sfr_rd_hit !== 1'b0 || sfr_rd_byte !== 8'h00 || irq !== 1'b0) begin
         errors++;
         $display("FAIL rst_rd got %b/%h/%b exp 0/00/0", sfr_rd_hit, sfr_rd_byte, irq);
      end
      checks++;
      if (pin_out !== 16'hFFFF || pin_oe !== 16'hFFFF) begin
         errors++;
         $display("FAIL rst_pins got %h/%h exp FFFF/FFFF", pin_out, pin_oe);
      end
      do_wr(8'hCC, 8'h01);
      idle(6);
      do_rd(8'hCD, b, h);
      checks++;
      if (b !== 8'h00) begin
         errors++;
         $display("FAIL settle got %h exp 00", b);
      end
      do_rd(8'hCB, b, h);
      checks++;
      if (b !== 8'h00) begin
         errors++;
         $display("FAIL rst_ien got %h exp 00", b);
      end
      do_rd(8'hC1, b, h);
      checks++;
      if (b !== 8'hFF || irq !== 1'b0) begin
         errors++;
         $display("FAIL rst_dir got %h/%b exp FF/0", b, irq);
      end
   endtask

   initial begin
      rst         = 1'b1;
      sfr_rd_en   = 1'b0;
      sfr_rd_addr = 8'h00;
      sfr_wr_en   = 1'b0;
      sfr_wr_addr = 8'h00;
      sfr_wr_byte = 8'h00;
      pin_in      = 16'hA55A;
      test_reset();
      test_rw();
      test_edge_irq();
      test_w1c();
      test_decode();
      test_reset_midread();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
